hamming_serial_tx: RTL and testbench
====================================

// Module: hamming_serial_tx
// PURPOSE
// - Link transmitter paired with the SECDED serial receiver: takes a 4-bit nibble on a load strobe.
// - Encodes it into an 8-bit Hamming(8,4) SECDED codeword and shifts it out as a framed serial stream.
// - Drives a forwarded bit clock and honours the receiver's not-ready backpressure.
// - Sits between the board's hex switch/button input logic and the serial pin in the TRX top level.
// PARAMETERS
// - CLK_DIV  8  system clocks per serial bit; even, >=2 (other values illegal, not checked in RTL)
// PORTS
// - clk            in   1  system clock; all logic on rising edge
// - rst            in   1  synchronous reset, active-high
// - data_in        in   4  nibble to send; sampled only on an accepted load
// - load           in   1  single-cycle request to send data_in
// - rx_not_ready   in   1  remote receiver backpressure; 1 = do not start a frame
// - busy           out  1  1 from the cycle after an accepted load until the frame completes
// - frame_done     out  1  one-cycle pulse when the stop bit completes
// - tx_serial_out  out  1  serial line; idles high
// - tx_clk         out  1  forwarded bit clock; receiver samples on its rising edge
// BEHAVIOUR
// - Reset values: tx_serial_out=1, tx_clk=0, busy=0, frame_done=0, FSM=IDLE, counters=0.
// - Encoding, with d=data_in latched on load:
//   - c0=d0^d1^d3, c1=d0^d2^d3, c2=d0, c3=d1^d2^d3, c4=d1, c5=d2, c6=d3
//   - c7 = XOR of c6..c0 (even overall parity)
// - Frame is 10 bits of CLK_DIV clocks each: start bit 0, then c0..c7 LSB first, then stop bit 1.
// - tx_clk is 0 for the first CLK_DIV/2 clocks of each bit and 1 for the second half.
// - tx_clk toggles only in START, DATA and STOP; it is held 0 otherwise.
// - FSM transitions:
//   - IDLE: load=1 latches data_in and codeword -> WAIT_RDY.
//   - WAIT_RDY: if rx_not_ready=0 -> START in the same cycle; otherwise hold, line high.
//   - START -> DATA after CLK_DIV clocks.
//   - DATA -> STOP after 8 bits.
//   - STOP -> IDLE after CLK_DIV clocks; frame_done=1 and busy=0 on the cycle IDLE is entered.
// - Latency: load at cycle 0 with rx_not_ready=0 -> busy=1 and tx_serial_out=0 at cycle 1.
//   - Frame occupies cycles 1..10*CLK_DIV; frame_done pulses at cycle 10*CLK_DIV+1.
// - load while busy=1 is ignored; there is no queue and data_in is not re-sampled.
// - load on the same cycle frame_done pulses (IDLE) is accepted.
// - rx_not_ready is evaluated only in WAIT_RDY; changes mid-frame do not stall or abort the frame.
// - rst mid-frame: the next cycle returns all outputs to reset values; the partial frame is
//   abandoned with no frame_done pulse.
// - Bit counter: 4 bits, wraps to 0 at frame end. Divider counter: clog2(CLK_DIV) bits,
//   wraps at CLK_DIV-1.
// CONFIGURATION
// - ERR_INJECT_EN defined:
//   - Adds input port inject[1:0], latched with load.
//   - 00: no error. 01: codeword bit c2 inverted on the line. 10: bits c2 and c4 inverted.
//   - 11: reserved, behaves as 00.
//   - Used to exercise the receiver's correctable/uncorrectable flags.
// - ERR_INJECT_EN undefined: no inject port; the codeword is always sent unmodified.
// TESTING
// - data_in=4'hB, load, rx_not_ready=0 -> codeword 8'h55;
//   line 0,1,0,1,0,1,0,1,0,1; frame_done at cycle 81 (CLK_DIV=8).
// - data_in=4'h1 -> codeword 8'h87; line bits after start 1,1,1,0,0,0,0,1; then stop 1.
// - rx_not_ready=1 for 20 cycles after load of 4'hF -> line high, tx_clk=0, busy=1;
//   start bit begins the cycle rx_not_ready drops; codeword 8'hFF.
// - Second load mid-frame with data_in=4'h0 -> ignored; first frame completes unchanged;
//   load at the frame_done cycle is accepted and sends 8'h00.
// - rst asserted at cycle 30 of a frame -> next cycle tx_serial_out=1, tx_clk=0, busy=0;
//   no frame_done pulse.
// - ERR_INJECT_EN: data 4'hB with inject=01 -> 8'h51 on the line; inject=10 -> 8'h41.

Source files
------------

// File: rtl/hamming_serial_tx_if.sv
// rtl/hamming_serial_tx_if.sv - host/line signal bundle for the Hamming(8,4) serial transmitter
// Optional inject field is present only when ERR_INJECT_EN is defined.
interface hamming_serial_tx_if;
  logic [3:0] data_in;
  logic       load;
  logic       rx_not_ready;
`ifdef ERR_INJECT_EN
  logic [1:0] inject;
`endif
  logic       busy;
  logic       frame_done;
  logic       tx_serial_out;
  logic       tx_clk;

  modport master (
`ifdef ERR_INJECT_EN
    output inject,
`endif
    output data_in, load, rx_not_ready,
    input  busy, frame_done, tx_serial_out, tx_clk
  );

  modport slave (
`ifdef ERR_INJECT_EN
    input  inject,
`endif
    input  data_in, load, rx_not_ready,
    output busy, frame_done, tx_serial_out, tx_clk
  );
endinterface

// File: rtl/hamming_serial_tx.sv
// rtl/hamming_serial_tx.sv - Hamming(8,4) SECDED encoder with framed serial output and forwarded bit clock
// ERR_INJECT_EN adds a latched inject[1:0] that corrupts c2 (01) or c2+c4 (10) on the line.
module hamming_serial_tx #(
  parameter int CLK_DIV = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  hamming_serial_tx_if.slave   bus
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [3:0]       bit_cnt, bit_nxt;
  logic [7:0]       code_q, code_nxt;
  logic             done_q, done_nxt;
  logic [7:0]       code_enc;
  logic [7:0]       err_mask;
  logic             line;
  logic             bit_clk;
  logic             div_last;

  function automatic logic [7:0] encode(input logic [3:0] d);
    logic [7:0] c;
    c[0] = d[0] ^ d[1] ^ d[3];
    c[1] = d[0] ^ d[2] ^ d[3];
    c[2] = d[0];
    c[3] = d[1] ^ d[2] ^ d[3];
    c[4] = d[1];
    c[5] = d[2];
    c[6] = d[3];
    c[7] = ^c[6:0];
    return c;
  endfunction

  assign code_enc = encode(bus.data_in);

`ifdef ERR_INJECT_EN
  always_comb begin
    err_mask = 8'h00;
    case (bus.inject)
      2'b01:   err_mask = 8'h04;
      2'b10:   err_mask = 8'h14;
      default: err_mask = 8'h00;
    endcase
  end
`else
  assign err_mask = 8'h00;
`endif

  assign div_last = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      code_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_nxt;
      bit_cnt <= bit_nxt;
      code_q  <= code_nxt;
      done_q  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    bit_nxt   = bit_cnt;
    code_nxt  = code_q;
    done_nxt  = 1'b0;
    line      = 1'b1;
    bit_clk   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.load) begin
          code_nxt  = code_enc ^ err_mask;
          div_nxt   = '0;
          bit_nxt   = '0;
          state_nxt = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        // The release cycle is already the first clock of the start bit.
        if (!bus.rx_not_ready) begin
          line      = 1'b0;
          div_nxt   = DIV_W'(1);
          state_nxt = START;
        end
      end
      START: begin
        line    = 1'b0;
        bit_clk = (div_cnt >= DIV_HALF);
        if (div_last) begin
          div_nxt   = '0;
          state_nxt = DATA;
        end else begin
          div_nxt = div_cnt + DIV_W'(1);
        end
      end
      DATA: begin
        line    = code_q[bit_cnt[2:0]];
        bit_clk = (div_cnt >= DIV_HALF);
        if (div_last) begin
          div_nxt = '0;
          if (bit_cnt == 4'd7) begin
            bit_nxt   = '0;
            state_nxt = STOP;
          end else begin
            bit_nxt = bit_cnt + 4'd1;
          end
        end else begin
          div_nxt = div_cnt + DIV_W'(1);
        end
      end
      STOP: begin
        bit_clk = (div_cnt >= DIV_HALF);
        if (div_last) begin
          div_nxt   = '0;
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else begin
          div_nxt = div_cnt + DIV_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.tx_serial_out = line;
  assign bus.tx_clk        = bit_clk;
  assign bus.busy          = (state != IDLE);
  assign bus.frame_done    = done_q;

endmodule

// File: tb/tb_hamming_serial_tx.sv
// tb/tb_hamming_serial_tx.sv - randomized self-checking bench for hamming_serial_tx
// Honours ERR_INJECT_EN when the bundle is built with it.
module tb_hamming_serial_tx;

  localparam int CLK_DIV = 8;
  localparam int FRAME   = 10 * CLK_DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hamming_serial_tx_if bus ();

  hamming_serial_tx #(.CLK_DIV(CLK_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] rx_code;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_code(input logic [3:0] d, input logic [1:0] inj);
    logic [7:0] c;
    c[0] = d[0] ^ d[1] ^ d[3];
    c[1] = d[0] ^ d[2] ^ d[3];
    c[2] = d[0];
    c[3] = d[1] ^ d[2] ^ d[3];
    c[4] = d[1];
    c[5] = d[2];
    c[6] = d[3];
    c[7] = ^c[6:0];
    if (inj == 2'b01) c = c ^ 8'h04;
    else if (inj == 2'b10) c = c ^ 8'h14;
    return c;
  endfunction

  function automatic logic [3:0] outs();
    return {bus.tx_serial_out, bus.tx_clk, bus.busy, bus.frame_done};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in an IDLE window; leaves in the frame_done window so the next call loads there.
  task automatic run_frame(input logic [3:0] d, input logic [1:0] inj, input int stall, input bit noise);
    logic [7:0] code;
    logic       fbits[$];
    logic [9:0] rx_frame;
    int         idx;
    logic       prev_clk;
    logic [3:0] o;
    bus.data_in      = d;
    bus.load         = 1'b1;
    bus.rx_not_ready = 1'b0;
`ifdef ERR_INJECT_EN
    bus.inject = inj;
    code = ref_code(d, inj);
`else
    code = ref_code(d, 2'b00);
`endif
    fbits.delete();
    fbits.push_back(1'b0);
    for (int i = 0; i < 8; i++) fbits.push_back(code[i]);
    fbits.push_back(1'b1);

    for (int k = 1; k <= stall; k++) begin
      tick();
      bus.load         = noise && ($urandom_range(0, 3) == 0);
      bus.data_in      = 4'($urandom);
      bus.rx_not_ready = 1'b1;
      #1;
      check("stall", 32'(outs()), 32'(4'b1010));
    end

    rx_frame = '0;
    idx      = 0;
    prev_clk = 1'b0;
    for (int f = 0; f < FRAME; f++) begin
      tick();
      bus.load         = noise && (f > 0) && ($urandom_range(0, 15) == 0);
      bus.data_in      = noise ? 4'($urandom) : 4'h0;
      bus.rx_not_ready = (f > 0) && noise && $urandom_range(0, 1) == 1;
      #1;
      o = outs();
      check("frame", 32'(o), 32'({fbits[f / CLK_DIV], ((f % CLK_DIV) >= CLK_DIV / 2), 1'b1, 1'b0}));
      if (o[2] && !prev_clk && idx < 10) begin
        rx_frame[idx] = o[3];
        idx++;
      end
      prev_clk = o[2];
    end

    tick();
    bus.load         = 1'b0;
    bus.rx_not_ready = 1'b0;
    #1;
    check("done", 32'(outs()), 32'(4'b1001));
    check("edges", 32'(idx), 32'd10);
    check("framing", 32'({rx_frame[9], rx_frame[0]}), 32'(2'b10));
    rx_code = rx_frame[8:1];
    check("codeword", 32'(rx_code), 32'(code));
  endtask

  initial begin
    bus.data_in      = 4'h0;
    bus.load         = 1'b0;
    bus.rx_not_ready = 1'b0;
`ifdef ERR_INJECT_EN
    bus.inject = 2'b00;
`endif
    rst = 1'b1;
    repeat (3) tick();
    check("reset", 32'(outs()), 32'(4'b1000));
    rst = 1'b0;
    tick();
    check("idle", 32'(outs()), 32'(4'b1000));

    run_frame(4'hB, 2'b00, 0, 1'b0);
    check("code_b", 32'(rx_code), 32'h55);
    run_frame(4'h1, 2'b00, 0, 1'b0);
    check("code_1", 32'(rx_code), 32'h87);
    run_frame(4'hF, 2'b00, 20, 1'b0);
    check("code_f_stall", 32'(rx_code), 32'hFF);
    run_frame(4'hF, 2'b00, 0, 1'b1);
    check("code_f_noise", 32'(rx_code), 32'hFF);
    run_frame(4'h0, 2'b00, 0, 1'b0);
    check("code_0", 32'(rx_code), 32'h00);
`ifdef ERR_INJECT_EN
    run_frame(4'hB, 2'b01, 0, 1'b0);
    check("inject_01", 32'(rx_code), 32'h51);
    run_frame(4'hB, 2'b10, 0, 1'b0);
    check("inject_10", 32'(rx_code), 32'h41);
    run_frame(4'hB, 2'b11, 0, 1'b0);
    check("inject_11", 32'(rx_code), 32'h55);
`endif

    // Abandon a frame with reset at cycle 30.
    bus.data_in = 4'h6;
    bus.load    = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      bus.load = 1'b0;
    end
    rst = 1'b1;
    tick();
    check("rst_mid", 32'(outs()), 32'(4'b1000));
    rst = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      #1;
      check("after_rst", 32'(outs()), 32'(4'b1000));
    end

    for (int n = 0; n < 12; n++) begin
      run_frame(4'($urandom), 2'($urandom), $urandom_range(0, 4), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
